// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - 32-bit word UART transmitter, four 8N1 frames LSB byte first
// One-word holding register lets the next word wait so back-to-back words leave no line gap.
module uart_word_tx #(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wword,
  input  logic        wword_valid,
  output logic        wword_ready,
  output logic        busy,
  output logic        txd
);

  localparam int BIT_CYCLES = 2 * CLK_PER_HALF_BIT;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [31:0]      shift;
  logic [31:0]      hold;
  logic             hold_full;
  logic [7:0]       cur_byte;

  logic bit_end, accept, last_byte, load, next_byte;

  assign bit_end   = (cnt == CNT_LAST);
  assign accept    = wword_valid & ~hold_full;
  assign last_byte = (byte_idx == 2'd3);
  assign load      = hold_full & ((state == IDLE) | ((state == STOP) & bit_end & last_byte));
  assign next_byte = (state == STOP) & bit_end & ~last_byte;
  assign cur_byte  = shift[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (hold_full) state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (bit_end) state_next = (~last_byte | hold_full) ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wword_ready = ~hold_full;
    busy        = (state != IDLE) | hold_full;
  end

  // Datapath: holding register, bit-period counter, shift register and the registered line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      bit_idx   <= 3'd0;
      byte_idx  <= 2'd0;
      shift     <= 32'd0;
      hold      <= 32'd0;
      hold_full <= 1'b0;
      txd       <= 1'b1;
    end else begin
      if (accept) hold <= wword;
      if (load)        hold_full <= 1'b0;
      else if (accept) hold_full <= 1'b1;

      if (state == IDLE || bit_end) cnt <= '0;
      else                          cnt <= cnt + CNT_W'(1);

      if (load) begin
        shift    <= hold;
        byte_idx <= 2'd0;
        txd      <= 1'b0;
      end else begin
        case (state)
          START: if (bit_end) begin
            txd     <= cur_byte[0];
            bit_idx <= 3'd0;
          end
          DATA: if (bit_end) begin
            txd     <= (bit_idx == 3'd7) ? 1'b1 : cur_byte[bit_idx + 3'd1];
            bit_idx <= bit_idx + 3'd1;
          end
          STOP: if (next_byte) begin
            byte_idx <= byte_idx + 2'd1;
            shift    <= shift >> 8;
            txd      <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - scoreboard bench for uart_word_tx with a line-decoding receiver model
module tb_uart_word_tx;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] wword = 32'd0;
  logic        wword_valid = 1'b0;
  logic        wword_ready, busy, txd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int words_tx = 0;
  int words_rx = 0;
  logic [31:0] exp_q[$];
  int          start_q[$];

  uart_word_tx #(.CLK_PER_HALF_BIT(4)) dut (
    .clk(clk), .reset(rst), .wword(wword), .wword_valid(wword_valid),
    .wword_ready(wword_ready), .busy(busy), .txd(txd)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic send(input logic [31:0] w, output int acc);
    int n = 0;
    while (wword_ready !== 1'b1 && n < 2000) begin step(); n++; end
    if (n >= 2000) check("send_timeout", 32'd1, 32'd0);
    wword = w;
    wword_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(w);
    words_tx++;
    #1;
    acc = cyc;
    wword_valid = 1'b0;
    wword = $urandom;
  endtask

  task automatic pop_start(input string name, input int req);
    if (start_q.size() == 0) check(name, 32'hFFFFFFFF, req);
    else check(name, start_q.pop_front(), req);
  endtask

  // Receiver model: samples txd mid-bit on falling clock edges, 8 cycles per bit.
  int          m_cnt, m_bytes = 0, m_prev;
  logic        m_active = 1'b0;
  logic [7:0]  m_byte;
  logic [31:0] m_word;
  always @(negedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_bytes  = 0;
    end else if (!m_active) begin
      if (txd === 1'b0) begin
        m_active = 1'b1;
        m_cnt = 0;
        if (m_bytes == 0) start_q.push_back(cyc);
        else check("byte_gap", cyc, m_prev + 80);
        m_prev = cyc;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 4) check("start_bit", txd, 32'd0);
      else if (m_cnt > 4 && m_cnt < 76 && (m_cnt % 8) == 4) m_byte[(m_cnt - 12) / 8] = txd;
      else if (m_cnt == 76) begin
        check("stop_bit", txd, 32'd1);
        m_active = 1'b0;
        m_word[m_bytes*8 +: 8] = m_byte;
        m_bytes++;
        if (m_bytes == 4) begin
          m_bytes = 0;
          words_rx++;
          if (exp_q.size() == 0) check("unexpected_word", m_word, 32'hXXXXXXXX);
          else check("word", m_word, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int c0, c1, c2, c3, f1, f3, n;
    logic bad;

    #2 rst = 1'b1;
    #1;
    check("reset_txd", txd, 32'd1);
    check("reset_ready", wword_ready, 32'd1);
    check("reset_busy", busy, 32'd0);
    clk_run = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    bad = 1'b0;
    repeat (100) begin
      step();
      if (txd !== 1'b1 || busy !== 1'b0 || wword_ready !== 1'b1) bad = 1'b1;
    end
    check("idle_100", bad, 32'd0);

    send(32'h44332211, c0);
    check("ready_after_accept", wword_ready, 32'd0);
    check("busy_after_accept", busy, 32'd1);
    check("txd_before_load", txd, 32'd1);
    step();
    check("first_fall", txd, 32'd0);
    check("ready_after_load", wword_ready, 32'd1);
    wait_cyc(c0 + 320);
    check("busy_last_stop", busy, 32'd1);
    check("txd_last_stop", txd, 32'd1);
    wait_cyc(c0 + 321);
    check("busy_fall", busy, 32'd0);
    check("txd_idle", txd, 32'd1);
    repeat (4) step();
    pop_start("start_w1", c0 + 1);

    send(32'hDEADBEEF, c1);
    f1 = c1 + 1;
    wait_cyc(c1 + 10);
    send(32'h01234567, c2);
    check("accept_edge", c2, c1 + 11);
    check("ready_hold_full", wword_ready, 32'd0);
    wait_cyc(c2 + 5);
    wword = 32'hFFFFFFFF;
    wword_valid = 1'b1;
    check("ready_blocked", wword_ready, 32'd0);
    repeat (20) step();
    wword_valid = 1'b0;
    wait_cyc(f1 + 319);
    check("ready_before_reload", wword_ready, 32'd0);
    wait_cyc(f1 + 320);
    check("ready_on_reload", wword_ready, 32'd1);
    check("second_start", txd, 32'd0);
    wait_cyc(f1 + 639);
    check("busy_before_end", busy, 32'd1);
    wait_cyc(f1 + 640);
    check("line_activity_640", busy, 32'd0);
    repeat (4) step();
    pop_start("start_w2", f1);
    pop_start("start_w3", f1 + 320);
    repeat (400) step();
    check("blocked_not_sent", start_q.size(), 32'd0);

    send(32'h00000000, c3);
    f3 = c3 + 1;
    wait_cyc(f3 + 100);
    check("pre_reset_line", txd, 32'd0);
    #2 rst = 1'b1;
    exp_q.delete();
    words_tx--;
    #1;
    check("abort_txd", txd, 32'd1);
    check("abort_busy", busy, 32'd0);
    check("abort_ready", wword_ready, 32'd1);
    repeat (3) step();
    rst = 1'b0;
    start_q.delete();
    repeat (10) step();
    check("post_abort_txd", txd, 32'd1);
    send(32'hA5A5A5A5, c3);

    send(32'h00000000, c3);
    send(32'hFFFFFFFF, c3);
    send(32'h80000001, c3);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 40)) step();
      send($urandom, c3);
    end

    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 20000) begin step(); n++; end
    repeat (10) step();
    check("drain", exp_q.size(), 32'd0);
    check("word_count", words_rx, words_tx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Transmit-side counterpart of the uart_word receiver.
- Accepts a 32-bit word through a valid/ready handshake and serialises it on txd as four 8N1 UART frames. Byte order is least-significant first: wword[7:0], then [15:8], [23:16], [31:24].
- A one-word holding register allows the next word to be accepted while the current word is on the line, so back-to-back words leave no idle gap.
- The bit-level serialiser is internal to this block; no separate byte-TX module is used.

Parameters:
- CLK_PER_HALF_BIT, 5208, clk cycles per half UART bit. One bit period is 2*CLK_PER_HALF_BIT cycles. Legal values are 2 and above.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- wword  input  32  word to transmit. Sampled only on an accepting edge.
- wword_valid  input  1  a word is offered.
- wword_ready  output  1  the holding register is empty. A word is accepted on a rising edge where wword_valid & wword_ready.
- busy  output  1  the serialiser is active or the holding register is full.
- txd  output  1  UART line. Idles high. Driven from a register.

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - txd=1, wword_ready=1, busy=0.
  - State=IDLE. Holding register emptied. All counters cleared.
  - Any in-flight word is discarded.
- Handshake:
  - wword_ready = ~hold_full.
  - An accepting edge loads wword into hold and sets hold_full.
  - wword_valid while wword_ready=0 is ignored; nothing is captured.
  - wword need not remain stable after acceptance.
- Serialiser state machine: IDLE, START, DATA, STOP.
  - Counters: cycle counter 0..2*CLK_PER_HALF_BIT-1; bit index 0..7; byte index 0..3.
  - IDLE & hold_full: on the next edge, move hold into the 32-bit shift register, clear hold_full, byte=0, go to START, txd<=0.
  - START: lasts one bit period. Then go to DATA, txd<=shift[0].
  - DATA: each bit lasts one bit period. Bits go LSB first. After bit 7, go to STOP, txd<=1.
  - STOP: lasts one full bit period. At its final edge:
    - byte<3: byte+1, shift right by 8, go to START, txd<=0. No idle between bytes.
    - byte==3 & hold_full: reload from hold, clear hold_full, go to START, txd<=0. No idle between words.
    - byte==3 & ~hold_full: go to IDLE, txd stays 1.
- Latency: word accepted at edge E0 → load and txd falls at edge E0+1 (serialiser idle). wword_ready is 1 again after E0+1.
- Load precedence: a hold→shift load and a new acceptance cannot coincide, because wword_ready=0 whenever hold is full.
- Timing: one word occupies exactly 40 bit periods = 80*CLK_PER_HALF_BIT cycles of txd.
- busy = (state≠IDLE) | hold_full. It falls on the same edge the last stop bit ends with hold empty.
- No parity. No break generation. No flow control.

Test Plan (CLK_PER_HALF_BIT=4, bit period = 8 cycles):
1. Assert reset mid-idle, no clock running → txd=1, wword_ready=1, busy=0 immediately. Stays so for 100 cycles after release with wword_valid=0.
2. Send 0x44332211 on one edge → txd low one edge later. Observed bits (8 cycles each):
   - 0,1,0,0,0,1,0,0,0,1 (byte 0x11),
   - then frames for 0x22, 0x33, 0x44.
   - Line returns to idle 320 cycles after the first falling edge; busy deasserts on that edge.
3. Back-to-back: send 0xDEADBEEF, then 0x01234567 ten cycles later (accepted, ready drops to 0).
   - Second word's start bit follows the 0xDE stop bit with zero idle cycles.
   - Ready returns to 1 on that load edge.
   - Total line activity is 640 cycles.
4. Offer a third word 0xFFFFFFFF while wword_ready=0 → never transmitted; only two words appear on txd.
5. Assert reset (async) during byte1 DATA → txd=1 before the next clock edge. After release, 0xA5A5A5A5 is transmitted bit-exact with no residue from the aborted word.
6. Loopback txd into a uart_word receiver with the same parameter. Send 0x00000000, 0xFFFFFFFF, 0x80000001 back-to-back → rword matches each word, rword_ready pulses once per word, ferr=0.
